// File: rtl/ysyx_22040386_pkg.sv
// Shared constants for the ysyx_22040386 core pipeline.
package ysyx_22040386_pkg;

    localparam int          XLEN     = 64;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040386_ifid_buf_if.sv
// IF -> buffer -> ID handshake bundle; master is the surrounding pipeline, slave is the buffer.
interface ysyx_22040386_ifid_buf_if #(
    parameter int DEPTH = 2
);
    import ysyx_22040386_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic            i_IFID_valid;
    logic [XLEN-1:0] i_IFID_pc;
    logic [31:0]     i_IFID_inst;
    logic            o_IFID_ready;
    logic            i_IFID_flush;
    logic            o_IFID_valid;
    logic [XLEN-1:0] o_IFID_pc;
    logic [31:0]     o_IFID_inst;
    logic            i_IFID_ready;
    logic [CW-1:0]   o_IFID_count;

    modport slave (
        input  i_IFID_valid, i_IFID_pc, i_IFID_inst, i_IFID_flush, i_IFID_ready,
        output o_IFID_ready, o_IFID_valid, o_IFID_pc, o_IFID_inst, o_IFID_count
    );

    modport master (
        output i_IFID_valid, i_IFID_pc, i_IFID_inst, i_IFID_flush, i_IFID_ready,
        input  o_IFID_ready, o_IFID_valid, o_IFID_pc, o_IFID_inst, o_IFID_count
    );

endinterface

// File: rtl/ysyx_22040386_ifid_buf.sv
// In-order DEPTH-entry FIFO between IF and ID; absorbs decode back-pressure and
// drops all buffered instructions on a redirect flush.
module ysyx_22040386_ifid_buf
    import ysyx_22040386_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          i_IFID_clk,
    input  logic                          i_IFID_rst_n,
    ysyx_22040386_ifid_buf_if.slave       bus
);

    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam int            EW   = XLEN + 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.i_IFID_valid & ~w_full  & ~bus.i_IFID_flush;
    assign w_pop   = ~w_empty & bus.i_IFID_ready & ~bus.i_IFID_flush;

    // Storage carries no reset so it can map onto plain flops / distributed RAM.
    always_ff @(posedge i_IFID_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.i_IFID_pc, bus.i_IFID_inst};
        end
    end

    always_ff @(posedge i_IFID_clk or negedge i_IFID_rst_n) begin
        if (!i_IFID_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.i_IFID_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = r_mem[r_rptr];

    // Empty head shows a NOP at PC 0 so decode never sees stale array contents.
    assign bus.o_IFID_ready = ~w_full;
    assign bus.o_IFID_valid = ~w_empty;
    assign bus.o_IFID_pc    = w_empty ? '0       : w_head[EW-1:32];
    assign bus.o_IFID_inst  = w_empty ? INST_NOP : w_head[31:0];
    assign bus.o_IFID_count = r_count;

endmodule

// File: tb/tb_ysyx_22040386_ifid_buf.sv
// Directed checks of the IF/ID instruction buffer with DEPTH=2.
module tb_ysyx_22040386_ifid_buf;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ysyx_22040386_ifid_buf_if #(.DEPTH(2)) bus ();

    ysyx_22040386_ifid_buf #(.DEPTH(2)) dut (
        .i_IFID_clk   (clk),
        .i_IFID_rst_n (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        bus.i_IFID_valid = v;
        bus.i_IFID_pc    = pc;
        bus.i_IFID_inst  = inst;
        bus.i_IFID_ready = rdy;
        bus.i_IFID_flush = fl;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [63:0] pc,
                              input logic [31:0] inst, input logic [63:0] cnt, input logic rdy);
        $display("step %s: valid=%0b pc=%h inst=%h count=%0d ready=%0b", tag,
                 bus.o_IFID_valid, bus.o_IFID_pc, bus.o_IFID_inst, bus.o_IFID_count, bus.o_IFID_ready);
        check({tag, "_valid"}, {63'd0, bus.o_IFID_valid}, {63'd0, v});
        check({tag, "_pc"},    bus.o_IFID_pc, pc);
        check({tag, "_inst"},  {32'd0, bus.o_IFID_inst}, {32'd0, inst});
        check({tag, "_count"}, {62'd0, bus.o_IFID_count}, cnt);
        check({tag, "_ready"}, {63'd0, bus.o_IFID_ready}, {63'd0, rdy});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        #3;
        check_head("reset", 1'b0, 64'h0, 32'h13, 64'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single push, held while ID stalls
        drive(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0);
        tick();
        check_head("push1", 1'b1, 64'h8000_0000, 32'h0000_0413, 64'd1, 1'b1);

        // Fill to DEPTH
        drive(1'b1, 64'h8000_0004, 32'h0000_0493, 1'b0, 1'b0);
        tick();
        check_head("fill", 1'b1, 64'h8000_0000, 32'h0000_0413, 64'd2, 1'b0);

        // Push into a full buffer is ignored
        drive(1'b1, 64'h8000_0008, 32'h0000_0513, 1'b0, 1'b0);
        tick();
        check_head("full_hold", 1'b1, 64'h8000_0000, 32'h0000_0413, 64'd2, 1'b0);

        // Full, ID consumes: pop only
        drive(1'b1, 64'h8000_0008, 32'h0000_0513, 1'b1, 1'b0);
        tick();
        check_head("full_pop", 1'b1, 64'h8000_0004, 32'h0000_0493, 64'd1, 1'b1);

        // Retry of the refused instruction is accepted
        drive(1'b1, 64'h8000_0008, 32'h0000_0513, 1'b0, 1'b0);
        tick();
        check_head("retry", 1'b1, 64'h8000_0004, 32'h0000_0493, 64'd2, 1'b0);

        // Flush with valid and ready asserted at count=2
        drive(1'b1, 64'h8000_000c, 32'h0000_0593, 1'b1, 1'b1);
        tick();
        check_head("flush", 1'b0, 64'h0, 32'h13, 64'd0, 1'b1);

        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_head("post_flush", 1'b0, 64'h0, 32'h13, 64'd0, 1'b1);

        // Streaming across pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0093 | (32'(i) << 20), 1'b1, 1'b0);
            tick();
            check_head($sformatf("stream%0d", i), 1'b1, 64'h8000_0000 + 64'(4 * i),
                       32'h0000_0093 | (32'(i) << 20), 64'd1, 1'b1);
        end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_head("drain", 1'b0, 64'h0, 32'h13, 64'd0, 1'b1);

        // Async reset mid-cycle with two entries
        drive(1'b1, 64'h8000_0100, 32'h0000_0613, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h8000_0104, 32'h0000_0693, 1'b0, 1'b0);
        tick();
        check_head("prefill", 1'b1, 64'h8000_0100, 32'h0000_0613, 64'd2, 1'b0);
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_head("async_rst", 1'b0, 64'h0, 32'h13, 64'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_head("after_rst", 1'b0, 64'h0, 32'h13, 64'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
